ddr3_buf_queue_regs: RTL and testbench

CSR-mapped descriptor queue for a parametrised number of DDR3 frame buffers, all in the `clk` domain. Software programs per-buffer base offsets and commits filled buffers in order. The DDR3 read engine consumes them from the head of a circular queue and retires each with `rd_done`. Occupancy, pointers and sticky error flags are readable over the CSR port. Any crossing into the DDR3 clock domain lies outside this block.

---
 rtl/ddr3_buf_queue_regs_if.sv | 30 +++
 rtl/ddr3_buf_queue_regs.sv | 163 ++++++++++++++++
 tb/tb_ddr3_buf_queue_regs.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_buf_queue_regs_if.sv
// CSR bus and read-engine handshake for the DDR3 frame-buffer descriptor queue.
// The master side is software plus the read engine; the slave side is the queue block.
interface ddr3_buf_queue_regs_if #(
    parameter int NUM_BUFS = 4,
    parameter int OFFSET_W = 26
);
    localparam int IDX_W = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1;

    logic                         csr_read;
    logic                         csr_write;
    logic [7:0]                   csr_addr;
    logic [31:0]                  csr_wr_data;
    logic [31:0]                  csr_rd_data;
    logic                         csr_rd_valid;
    logic [NUM_BUFS*OFFSET_W-1:0] buf_offset;
    logic                         rd_valid;
    logic [IDX_W-1:0]             rd_idx;
    logic [OFFSET_W-1:0]          rd_offset;
    logic                         rd_done;

    modport master (
        output csr_read, csr_write, csr_addr, csr_wr_data, rd_done,
        input  csr_rd_data, csr_rd_valid, buf_offset, rd_valid, rd_idx, rd_offset
    );

    modport slave (
        input  csr_read, csr_write, csr_addr, csr_wr_data, rd_done,
        output csr_rd_data, csr_rd_valid, buf_offset, rd_valid, rd_idx, rd_offset
    );
endinterface

// File: rtl/ddr3_buf_queue_regs.sv
// Circular descriptor queue of DDR3 frame buffers with CSR programming, in-order commit
// and head retirement; sticky overflow/underflow/write-while-full flags.
module ddr3_buf_queue_regs #(
    parameter int NUM_BUFS = 4,
    parameter int OFFSET_W = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ddr3_buf_queue_regs_if.slave  bus
);
    localparam int IDX_W = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1;
    localparam int CNT_W = $clog2(NUM_BUFS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_BUFS);
    localparam logic [7:0]       OFF_BASE = 8'h10;
    localparam logic [7:0]       OFF_END  = 8'(16 + NUM_BUFS);

    logic [OFFSET_W-1:0] r_offset [NUM_BUFS];
    logic [NUM_BUFS-1:0] r_full;
    logic [IDX_W-1:0]    r_head;
    logic [IDX_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_enable;
    logic                r_ovf;
    logic                r_unf;
    logic                r_wfe;
    logic [31:0]         r_scratch;
    logic [31:0]         r_rd_data;
    logic                r_rd_valid;

    logic                w_wr_ctrl;
    logic                w_wr_status;
    logic                w_commit;
    logic                w_wr_scratch;
    logic                w_off_hit;
    logic [IDX_W-1:0]    w_off_idx;
    logic                w_wr_off;
    logic                w_wr_frozen;
    logic                w_soft_clear;
    logic                w_commit_ok;
    logic                w_done_ok;
    logic                w_done_unf;
    logic [NUM_BUFS-1:0] w_full_next;
    logic [31:0]         w_rd_mux;

    function automatic logic [IDX_W-1:0] f_adv(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign w_wr_ctrl    = bus.csr_write && (bus.csr_addr == 8'h00);
    assign w_wr_status  = bus.csr_write && (bus.csr_addr == 8'h01);
    assign w_commit     = bus.csr_write && (bus.csr_addr == 8'h02);
    assign w_wr_scratch = bus.csr_write && (bus.csr_addr == 8'h04);
    assign w_off_hit    = (bus.csr_addr >= OFF_BASE) && (bus.csr_addr < OFF_END);
    assign w_off_idx    = bus.csr_addr[IDX_W-1:0];
    assign w_wr_off     = bus.csr_write && w_off_hit;
    assign w_wr_frozen  = w_wr_off && r_full[w_off_idx];
    assign w_soft_clear = w_wr_ctrl && bus.csr_wr_data[1];

    // Commit and retire are both judged against pre-edge state.
    assign w_commit_ok  = w_commit && (r_count != MAX_CNT);
    assign w_done_ok    = bus.rd_done && r_enable && (r_count != '0);
    assign w_done_unf   = bus.rd_done && r_enable && (r_count == '0);

    always_comb begin
        w_full_next = r_full;
        if (w_done_ok)
            w_full_next[r_head] = 1'b0;
        if (w_commit_ok)
            w_full_next[r_tail] = 1'b1;
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.csr_addr)
            8'h00: w_rd_mux[0] = r_enable;
            8'h01: begin
                w_rd_mux[CNT_W-1:0] = r_count;
                w_rd_mux[8]         = r_ovf;
                w_rd_mux[9]         = r_unf;
                w_rd_mux[10]        = r_wfe;
            end
            8'h03: begin
                w_rd_mux[IDX_W-1:0]  = r_head;
                w_rd_mux[8 +: IDX_W] = r_tail;
            end
            8'h04: w_rd_mux = r_scratch;
            8'h05: w_rd_mux[NUM_BUFS-1:0] = r_full;
            default: begin
                if (w_off_hit)
                    w_rd_mux[OFFSET_W-1:0] = r_offset[w_off_idx];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUFS; i++)
                r_offset[i] <= '0;
            r_full     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_enable   <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_wfe      <= 1'b0;
            r_scratch  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_enable <= bus.csr_wr_data[0];
            if (w_wr_scratch)
                r_scratch <= bus.csr_wr_data;

            if (w_commit && !w_commit_ok)
                r_ovf <= 1'b1;
            else if (w_wr_status && bus.csr_wr_data[8])
                r_ovf <= 1'b0;
            if (w_done_unf)
                r_unf <= 1'b1;
            else if (w_wr_status && bus.csr_wr_data[9])
                r_unf <= 1'b0;
            if (w_wr_frozen)
                r_wfe <= 1'b1;
            else if (w_wr_status && bus.csr_wr_data[10])
                r_wfe <= 1'b0;

            for (int i = 0; i < NUM_BUFS; i++) begin
                if (w_wr_off && !w_wr_frozen && (w_off_idx == IDX_W'(i)))
                    r_offset[i] <= bus.csr_wr_data[OFFSET_W-1:0];
            end

            // Soft clear wins over a same-cycle retire; a commit cannot coincide with it.
            if (w_soft_clear) begin
                r_full  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_full  <= w_full_next;
                r_head  <= w_done_ok   ? f_adv(r_head) : r_head;
                r_tail  <= w_commit_ok ? f_adv(r_tail) : r_tail;
                r_count <= r_count + CNT_W'(w_commit_ok) - CNT_W'(w_done_ok);
            end

            r_rd_valid <= bus.csr_read;
            if (bus.csr_read)
                r_rd_data <= w_rd_mux;
        end
    end

    assign bus.csr_rd_data  = r_rd_data;
    assign bus.csr_rd_valid = r_rd_valid;
    assign bus.rd_valid     = r_enable && (r_count != '0);
    assign bus.rd_idx       = r_head;
    assign bus.rd_offset    = r_offset[r_head];

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_off
        assign bus.buf_offset[g*OFFSET_W +: OFFSET_W] = r_offset[g];
    end
endmodule

// File: tb/tb_ddr3_buf_queue_regs.sv
// Directed, table-driven bench for the DDR3 buffer descriptor queue (4- and 3-buffer builds).
module tb_ddr3_buf_queue_regs;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel;
    logic        csr_read, csr_write, rd_done;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ddr3_buf_queue_regs_if #(.NUM_BUFS(4), .OFFSET_W(26)) if4 ();
    ddr3_buf_queue_regs_if #(.NUM_BUFS(3), .OFFSET_W(26)) if3 ();

    assign if4.csr_read    = csr_read  & ~sel;
    assign if4.csr_write   = csr_write & ~sel;
    assign if4.rd_done     = rd_done   & ~sel;
    assign if4.csr_addr    = addr;
    assign if4.csr_wr_data = wdata;
    assign if3.csr_read    = csr_read  & sel;
    assign if3.csr_write   = csr_write & sel;
    assign if3.rd_done     = rd_done   & sel;
    assign if3.csr_addr    = addr;
    assign if3.csr_wr_data = wdata;

    ddr3_buf_queue_regs #(.NUM_BUFS(4), .OFFSET_W(26)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if4)
    );
    ddr3_buf_queue_regs #(.NUM_BUFS(3), .OFFSET_W(26)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(if3)
    );

    logic [31:0] m_rd_data;
    logic        m_rd_valid, m_q_valid;
    logic [1:0]  m_idx;
    logic [25:0] m_off;
    assign m_rd_data  = sel ? if3.csr_rd_data  : if4.csr_rd_data;
    assign m_rd_valid = sel ? if3.csr_rd_valid : if4.csr_rd_valid;
    assign m_q_valid  = sel ? if3.rd_valid     : if4.rd_valid;
    assign m_idx      = sel ? if3.rd_idx       : if4.rd_idx;
    assign m_off      = sel ? if3.rd_offset    : if4.rd_offset;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_DONE, OP_HEAD} op_t;
    typedef struct {
        op_t         op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t vq[$];

    task automatic add(input op_t op, input logic [7:0] a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.e = e;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = a; wdata = d; csr_write = 1'b1;
        cyc();
        csr_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        addr = a; csr_read = 1'b1;
        cyc();
        csr_read = 1'b0;
        check($sformatf("rd_valid@%0h", a), 64'(m_rd_valid), 64'd1);
        check($sformatf("rd_data@%0h", a), 64'(m_rd_data), 64'(e));
        cyc();
        check($sformatf("rd_pulse@%0h", a), 64'(m_rd_valid), 64'd0);
    endtask

    task automatic done();
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
    endtask

    task automatic head(input logic [31:0] e);
        check("head", 64'({1'b0, m_q_valid, 2'b00, m_idx, m_off}), 64'(e));
    endtask

    task automatic both_commit_done();
        addr = 8'h02; wdata = '0; csr_write = 1'b1; rd_done = 1'b1;
        cyc();
        csr_write = 1'b0; rd_done = 1'b0;
    endtask

    initial begin
        sel = 1'b0; csr_read = 1'b0; csr_write = 1'b0; rd_done = 1'b0;
        addr = '0; wdata = '0;

        // Reset reads, then the four-buffer fill/drain walk
        foreach (vq[i]) ;
        for (int a = 0; a < 6; a++) add(OP_RD, 8'(a), 0, 0);
        for (int a = 16; a < 20; a++) add(OP_RD, 8'(a), 0, 0);
        add(OP_WR, 8'h10, 32'hFFFF_F000, 0);
        add(OP_WR, 8'h11, 32'h0000_0000, 0);
        add(OP_WR, 8'h12, 32'h0000_1000, 0);
        add(OP_WR, 8'h13, 32'h0000_2000, 0);
        add(OP_RD, 8'h10, 0, 32'h03FF_F000);
        add(OP_RD, 8'h13, 0, 32'h0000_2000);
        add(OP_WR, 8'h00, 32'h1, 0);
        add(OP_RD, 8'h00, 0, 32'h1);
        add(OP_HEAD, 0, 0, 32'h03FF_F000);
        add(OP_WR, 8'h02, 0, 0);
        add(OP_RD, 8'h01, 0, 32'h1);
        add(OP_WR, 8'h02, 0, 0);
        add(OP_WR, 8'h02, 0, 0);
        add(OP_WR, 8'h02, 0, 0);
        add(OP_RD, 8'h01, 0, 32'h4);
        add(OP_RD, 8'h05, 0, 32'hF);
        add(OP_RD, 8'h03, 0, 32'h0);
        add(OP_RD, 8'h02, 0, 32'h0);
        add(OP_HEAD, 0, 0, 32'h43FF_F000);
        add(OP_DONE, 0, 0, 0);
        add(OP_HEAD, 0, 0, 32'h4400_0000);
        add(OP_DONE, 0, 0, 0);
        add(OP_HEAD, 0, 0, 32'h4800_1000);
        add(OP_DONE, 0, 0, 0);
        add(OP_HEAD, 0, 0, 32'h4C00_2000);
        add(OP_DONE, 0, 0, 0);
        add(OP_HEAD, 0, 0, 32'h03FF_F000);
        add(OP_RD, 8'h01, 0, 32'h0);
        add(OP_RD, 8'h05, 0, 32'h0);
        add(OP_WR, 8'h04, 32'hDEAD_BEEF, 0);
        add(OP_RD, 8'h04, 0, 32'hDEAD_BEEF);
        add(OP_WR, 8'h20, 32'h1234_5678, 0);
        add(OP_RD, 8'h20, 0, 32'h0);
        add(OP_RD, 8'h14, 0, 32'h0);
        // disabled: commit accepted, done ignored; then underflow and W1C
        add(OP_WR, 8'h00, 32'h0, 0);
        add(OP_WR, 8'h02, 0, 0);
        add(OP_DONE, 0, 0, 0);
        add(OP_RD, 8'h01, 0, 32'h1);
        add(OP_WR, 8'h00, 32'h1, 0);
        add(OP_HEAD, 0, 0, 32'h43FF_F000);
        add(OP_DONE, 0, 0, 0);
        add(OP_RD, 8'h01, 0, 32'h0);
        add(OP_DONE, 0, 0, 0);
        add(OP_RD, 8'h01, 0, 32'h200);
        add(OP_WR, 8'h01, 32'h200, 0);
        add(OP_RD, 8'h01, 0, 32'h0);

        #12;
        check("reset csr_rd_valid", 64'(if4.csr_rd_valid), 0);
        check("reset csr_rd_data", 64'(if4.csr_rd_data), 0);
        check("reset rd_valid", 64'(if4.rd_valid), 0);
        check("reset rd_idx/offset", 64'({if4.rd_idx, if4.rd_offset}), 0);
        check("reset buf_offset", 64'(if4.buf_offset[63:0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        foreach (vq[i]) begin
            case (vq[i].op)
                OP_WR:   wr(vq[i].a, vq[i].d);
                OP_RD:   rd(vq[i].a, vq[i].e);
                OP_DONE: done();
                OP_HEAD: head(vq[i].e);
                default: ;
            endcase
        end

        // Three-buffer build: pointer wrap and overflow
        sel = 1'b1;
        wr(8'h00, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            wr(8'h02, 0);
            done();
            rd(8'h03, 32'((k % 3) << 8 | (k % 3)));
        end
        for (int k = 0; k < 4; k++) wr(8'h02, 0);
        rd(8'h01, 32'h103);
        rd(8'h05, 32'h7);
        wr(8'h01, 32'h100);
        rd(8'h01, 32'h3);

        // Simultaneous commit and retire on the four-buffer build
        sel = 1'b0;
        wr(8'h00, 32'h3);
        wr(8'h01, 32'h700);
        rd(8'h01, 32'h0);
        both_commit_done();
        rd(8'h01, 32'h201);
        wr(8'h02, 0);
        both_commit_done();
        rd(8'h01, 32'h202);
        rd(8'h03, 32'h0301);
        wr(8'h02, 0);
        wr(8'h02, 0);
        both_commit_done();
        rd(8'h01, 32'h303);
        rd(8'h03, 32'h0102);
        rd(8'h05, 32'hD);

        // Frozen offset write, free offset write, soft clear against rd_done
        wr(8'h12, 32'h123);
        rd(8'h12, 32'h1000);
        rd(8'h01, 32'h703);
        wr(8'h11, 32'h55);
        rd(8'h11, 32'h55);
        addr = 8'h00; wdata = 32'h3; csr_write = 1'b1; rd_done = 1'b1;
        cyc();
        csr_write = 1'b0; rd_done = 1'b0;
        rd(8'h01, 32'h700);
        rd(8'h03, 32'h0);
        rd(8'h05, 32'h0);
        rd(8'h00, 32'h1);
        rd(8'h12, 32'h1000);
        head(32'h03FF_F000);

        // Asynchronous reset with a read in flight
        wr(8'h02, 0);
        wr(8'h02, 0);
        rd(8'h01, 32'h702);
        head(32'h43FF_F000);
        addr = 8'h01; csr_read = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("async csr_rd_data", 64'(if4.csr_rd_data), 0);
        check("async csr_rd_valid", 64'(if4.csr_rd_valid), 0);
        check("async rd_valid", 64'(if4.rd_valid), 0);
        check("async rd_idx/offset", 64'({if4.rd_idx, if4.rd_offset}), 0);
        check("async buf_offset", 64'(if4.buf_offset[63:0]), 0);
        @(posedge clk);
        #1;
        csr_read = 1'b0;
        check("in-reset csr_rd_valid", 64'(if4.csr_rd_valid), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("post-reset csr_rd_valid", 64'(if4.csr_rd_valid), 0);
        rd(8'h01, 32'h0);
        rd(8'h10, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
